// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the program-ram arbiter.
// The RAM_ARB_STATS_EN build option lives in ram_arbiter.sv.
package ram_arb_pkg;
   typedef logic [7:0] addr_t;
   typedef logic [7:0] data_t;
   typedef enum logic {IDLE, LOCKED} arb_state_t;

   localparam int RAM_LATENCY = 1;

   function automatic logic out_of_range(input addr_t a, input int depth);
      return ({1'b0, a} >= 9'(depth));
   endfunction
endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid bit at or above ptr_i,
// wrapping modulo N, returned as a one-hot grant.
module rr_pick #(
   parameter int N = 2,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  valid_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  grant_o
);
   logic          found;
   logic [PW:0]   sum;

   always_comb begin
      grant_o = '0;
      found   = 1'b0;
      sum     = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr_i} + (PW+1)'(k);
         if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
         if (!found && valid_i[sum[PW-1:0]]) begin
            grant_o[sum[PW-1:0]] = 1'b1;
            found                = 1'b1;
         end
      end
   end
endmodule

// File: rtl/ram_arbiter.sv
// Round-robin read arbiter in front of the single-port program ram, with burst lock.
// Define RAM_ARB_STATS_EN to add saturating per-requester grant counters (stat_grants).
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int DEPTH = 128
) (
   input  logic              Clock,
   input  logic              nReset,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ-1:0]   req_lock,
   input  logic [8*NREQ-1:0] req_addr,
   output logic [NREQ-1:0]   req_ready,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [7:0]        rsp_data,
   output logic              rsp_err,
   output logic [7:0]        RamAddress,
   input  logic [7:0]        RamData
`ifdef RAM_ARB_STATS_EN
   ,
   output logic [16*NREQ-1:0] stat_grants
`endif
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_state_t      state_q, state_d;
   logic [PW-1:0]   owner_q, owner_d;
   logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
   addr_t           addr_q;
   logic [NREQ-1:0] pick_grant;
   logic [NREQ-1:0] grant;
   logic            accept;
   logic [PW-1:0]   win_idx;
   addr_t           win_addr;
   logic            win_lock;
   logic            err_out;

   // Response tag pipeline matches the ram read latency.
   logic [NREQ-1:0] rsp_vld_q [RAM_LATENCY];
   logic            rsp_err_q [RAM_LATENCY];

   rr_pick #(.N(NREQ)) u_pick (
      .valid_i (req_valid),
      .ptr_i   (rr_ptr_q),
      .grant_o (pick_grant)
   );

   always_comb begin
      grant = '0;
      case (state_q)
         IDLE: grant = pick_grant;
         LOCKED: begin
            for (int i = 0; i < NREQ; i++)
               if (PW'(i) == owner_q) grant[i] = req_valid[i];
         end
         default: grant = '0;
      endcase
   end

   assign accept    = |grant;
   assign req_ready = grant;

   always_comb begin
      win_idx  = '0;
      win_addr = '0;
      win_lock = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            win_idx  = PW'(i);
            win_addr = req_addr[8*i +: 8];
            win_lock = req_lock[i];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      if (accept) begin
         rr_ptr_d = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
         if (win_lock) begin
            state_d = LOCKED;
            owner_d = win_idx;
         end else begin
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (!nReset) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         addr_q   <= '0;
         for (int k = 0; k < RAM_LATENCY; k++) begin
            rsp_vld_q[k] <= '0;
            rsp_err_q[k] <= 1'b0;
         end
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         if (accept) addr_q <= win_addr;
         rsp_vld_q[0] <= grant;
         rsp_err_q[0] <= accept & out_of_range(win_addr, DEPTH);
         for (int k = 1; k < RAM_LATENCY; k++) begin
            rsp_vld_q[k] <= rsp_vld_q[k-1];
            rsp_err_q[k] <= rsp_err_q[k-1];
         end
      end
   end

   // Responses are masked while reset is held so an in-flight read is dropped.
   assign RamAddress = accept ? win_addr : addr_q;
   assign rsp_valid  = rsp_vld_q[RAM_LATENCY-1] & {NREQ{nReset}};
   assign err_out    = rsp_err_q[RAM_LATENCY-1] & nReset;
   assign rsp_err    = err_out;
   assign rsp_data   = err_out ? '0 : RamData;

`ifdef RAM_ARB_STATS_EN
   logic [15:0] cnt_q [NREQ];

   always_ff @(posedge Clock) begin
      if (!nReset) begin
         for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++)
            if (grant[i] && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
   end

   always_comb begin
      stat_grants = '0;
      for (int i = 0; i < NREQ; i++) stat_grants[16*i +: 16] = cnt_q[i];
   end
`endif
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed vector table, reset corner case, then
// randomized traffic against a rule-level model; stats check when RAM_ARB_STATS_EN.
module tb_ram_arbiter;
   localparam int NREQ  = 2;
   localparam int DEPTH = 128;

   logic        clk;
   logic        nReset;
   logic [1:0]  req_valid, req_lock, req_ready, rsp_valid;
   logic [15:0] req_addr;
   logic [7:0]  rsp_data, RamAddress, RamData;
   logic        rsp_err;
`ifdef RAM_ARB_STATS_EN
   logic [31:0] stat_grants;
`endif

   ram_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
      .Clock      (clk),
      .nReset     (nReset),
      .req_valid  (req_valid),
      .req_lock   (req_lock),
      .req_addr   (req_addr),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .RamAddress (RamAddress),
      .RamData    (RamData)
`ifdef RAM_ARB_STATS_EN
      ,
      .stat_grants(stat_grants)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The program ram itself: one-cycle synchronous read.
   logic [7:0] mem [256];
   always @(posedge clk) RamData <= mem[RamAddress];

   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [1:0] valid;
      logic [1:0] lock;
      logic [7:0] a0;
      logic [7:0] a1;
      logic [1:0] ready;
      logic [7:0] ram;
      logic [1:0] rspv;
      logic [7:0] data;
      logic       err;
   } vec_t;
   vec_t tbl [13];

   // Rule-level model state
   int         m_ptr, m_owner;
   bit         m_locked, m_pend;
   int         m_id;
   logic [7:0] m_addr, m_raddr;
   logic [1:0] prev_ready;

   function automatic logic [1:0] model_ready(input logic [1:0] v);
      if (m_locked) return v[m_owner] ? (2'b01 << m_owner) : 2'b00;
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (m_ptr + k) % NREQ;
         if (v[idx]) return 2'b01 << idx;
      end
      return 2'b00;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_owner = 0; m_locked = 0; m_pend = 0;
      m_id = 0; m_addr = 8'h00; m_raddr = 8'h00; prev_ready = 2'b00;
   endtask

   task automatic model_cycle();
      logic [1:0] er, ev;
      logic [7:0] ea, wa;
      int         w;
      @(negedge clk);
      er = model_ready(req_valid);
      w  = er[1] ? 1 : 0;
      wa = req_addr[8*w +: 8];
      ea = (er != 2'b00) ? wa : m_addr;
      check("rand_ready", req_ready, er);
      check("rand_ramaddr", RamAddress, ea);
      ev = (m_pend && nReset) ? (2'b01 << m_id) : 2'b00;
      check("rand_rspv", rsp_valid, ev);
      if (ev != 2'b00) begin
         check("rand_err", rsp_err, (m_raddr >= DEPTH));
         check("rand_data", rsp_data, (m_raddr >= DEPTH) ? 8'h00 : mem[m_raddr]);
      end
      prev_ready = er;
      if (!nReset) begin
         model_reset();
      end else if (er != 2'b00) begin
         m_addr  = wa;
         m_ptr   = (w + 1) % NREQ;
         m_pend  = 1;
         m_id    = w;
         m_raddr = wa;
         if (req_lock[w]) begin m_locked = 1; m_owner = w; end
         else m_locked = 0;
      end else begin
         m_pend = 0;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
      mem[8'h05] = 8'hA7;
      mem[8'h10] = 8'h3C;
      mem[8'h20] = 8'h5D;

      //          valid  lock   a0     a1     ready  ram    rspv   data   err
      tbl[0]  = '{2'b01, 2'b00, 8'h05, 8'h00, 2'b01, 8'h05, 2'b00, 8'h00, 1'b0};
      tbl[1]  = '{2'b00, 2'b00, 8'h05, 8'h00, 2'b00, 8'h05, 2'b01, 8'hA7, 1'b0};
      tbl[2]  = '{2'b11, 2'b00, 8'h10, 8'h20, 2'b10, 8'h20, 2'b00, 8'h00, 1'b0};
      tbl[3]  = '{2'b11, 2'b00, 8'h10, 8'h20, 2'b01, 8'h10, 2'b10, 8'h5D, 1'b0};
      tbl[4]  = '{2'b11, 2'b00, 8'h10, 8'h20, 2'b10, 8'h20, 2'b01, 8'h3C, 1'b0};
      tbl[5]  = '{2'b11, 2'b00, 8'h10, 8'h20, 2'b01, 8'h10, 2'b10, 8'h5D, 1'b0};
      tbl[6]  = '{2'b10, 2'b00, 8'h10, 8'h80, 2'b10, 8'h80, 2'b01, 8'h3C, 1'b0};
      tbl[7]  = '{2'b00, 2'b00, 8'h10, 8'h80, 2'b00, 8'h80, 2'b10, 8'h00, 1'b1};
      tbl[8]  = '{2'b11, 2'b01, 8'h05, 8'h20, 2'b01, 8'h05, 2'b00, 8'h00, 1'b0};
      tbl[9]  = '{2'b11, 2'b01, 8'h10, 8'h20, 2'b01, 8'h10, 2'b01, 8'hA7, 1'b0};
      tbl[10] = '{2'b11, 2'b00, 8'h05, 8'h20, 2'b01, 8'h05, 2'b01, 8'h3C, 1'b0};
      tbl[11] = '{2'b11, 2'b00, 8'h05, 8'h20, 2'b10, 8'h20, 2'b01, 8'hA7, 1'b0};
      tbl[12] = '{2'b00, 2'b00, 8'h05, 8'h20, 2'b00, 8'h20, 2'b10, 8'h5D, 1'b0};

      nReset = 1'b0; req_valid = 2'b00; req_lock = 2'b00; req_addr = 16'h0000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_rspv", rsp_valid, 2'b00);
      check("reset_err", rsp_err, 1'b0);
      check("reset_ramaddr", RamAddress, 8'h00);
      check("reset_ready", req_ready, 2'b00);
      @(posedge clk); #1;
      nReset = 1'b1;

      for (int r = 0; r < 13; r++) begin
         req_valid = tbl[r].valid;
         req_lock  = tbl[r].lock;
         req_addr  = {tbl[r].a1, tbl[r].a0};
         @(negedge clk);
         check($sformatf("vec%0d_ready", r), req_ready, tbl[r].ready);
         check($sformatf("vec%0d_ramaddr", r), RamAddress, tbl[r].ram);
         check($sformatf("vec%0d_rspv", r), rsp_valid, tbl[r].rspv);
         if (tbl[r].rspv != 2'b00) begin
            check($sformatf("vec%0d_data", r), rsp_data, tbl[r].data);
            check($sformatf("vec%0d_err", r), rsp_err, tbl[r].err);
         end
         @(posedge clk); #1;
      end

      // Accept from 0, then reset in the following cycle: response dropped, pointer back to 0.
      req_valid = 2'b01; req_lock = 2'b00; req_addr = {8'h20, 8'h05};
      @(negedge clk);
      check("rst_seq_ready", req_ready, 2'b01);
      @(posedge clk); #1;
      nReset = 1'b0; req_valid = 2'b00;
      @(negedge clk);
      check("rst_seq_no_rsp", rsp_valid, 2'b00);
      @(posedge clk); #1;
      nReset = 1'b1;
      @(negedge clk);
      check("rst_seq_ramaddr", RamAddress, 8'h00);
      check("rst_seq_rspv", rsp_valid, 2'b00);
      @(posedge clk); #1;
      req_valid = 2'b11; req_addr = {8'h20, 8'h10};
      @(negedge clk);
      check("rst_seq_first_grant", req_ready, 2'b01);
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(negedge clk);
      check("rst_seq_rsp", rsp_valid, 2'b01);
      check("rst_seq_data", rsp_data, 8'h3C);
      @(posedge clk); #1;

      // Randomized traffic against the model.
      nReset = 1'b0; req_valid = 2'b00;
      @(posedge clk); #1;
      nReset = 1'b1;
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         logic [1:0] v, l;
         logic [7:0] a [2];
         v = req_valid; l = req_lock; a[0] = req_addr[7:0]; a[1] = req_addr[15:8];
         for (int i = 0; i < NREQ; i++) begin
            if (!(req_valid[i] && !prev_ready[i] && nReset)) begin
               v[i] = ($urandom_range(0, 3) != 0);
               l[i] = ($urandom_range(0, 3) == 0);
               a[i] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(128, 255))
                                                  : 8'($urandom_range(0, 127));
            end
         end
         req_valid = v; req_lock = l; req_addr = {a[1], a[0]};
         nReset = ($urandom_range(0, 199) != 0);
         model_cycle();
      end
      nReset = 1'b1;

`ifdef RAM_ARB_STATS_EN
      req_valid = 2'b00;
      nReset = 1'b0;
      @(posedge clk); #1;
      nReset = 1'b1;
      req_valid = 2'b01; req_lock = 2'b00; req_addr = {8'h20, 8'h05};
      repeat (1000) @(posedge clk);
      #1;
      check("stat0_1000", stat_grants[15:0], 16'd1000);
      check("stat1_1000", stat_grants[31:16], 16'd0);
      repeat (69000) @(posedge clk);
      #1;
      check("stat0_sat", stat_grants[15:0], 16'hFFFF);
      check("stat1_sat", stat_grants[31:16], 16'd0);
      req_valid = 2'b00;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
